hb_mac_sched: RTL and testbench

Sequencer for a time-multiplexed 2:1 halfband decimator in the ADC filter chain. It manages the write pointer of an input-sample ring RAM and steps one shared multiply-accumulate unit through the 19 symmetric coefficient pairs plus the centre tap. It emits one decimated-output strobe per two input strobes. The RAM, coefficient ROM and MAC live in the datapath; this block owns only addressing, tap validity, accumulate control and flow status.

---
 rtl/hb_mac_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_hb_mac_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hb_mac_sched.sv
// Halfband 2:1 decimator MAC sequencer: ring write pointer, tap addressing/validity, accumulate control.
// Latency: start strobe at t -> MAC k=0 at t+1, CTR at t+20, clk_vld_out at t+20+PIPE.
// Backpressure: none; a start while busy goes to the pending slot (HB_MAC_SCHED_PEND_EN) or is dropped and sets ovf.
module hb_mac_sched #(
    parameter int AW   = 7,
    parameter int PIPE = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_vld_in,
    input  logic          ovf_clr,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic          rd_a_vld,
    output logic          rd_b_vld,
    output logic [4:0]    coef_idx,
    output logic          coef_neg,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          busy,
    output logic          clk_vld_out,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        CTR  = 2'd2
    } state_t;

    localparam logic [6:0] FILL_MAX = 7'd76;
    localparam logic [4:0] K_LAST   = 5'd18;

    state_t          state_q, state_d;
    logic [4:0]      k_q, k_d;
    logic [AW-1:0]   base_q, base_d;
    logic [6:0]      fcap_q, fcap_d;
    logic [6:0]      fill_q, fill_nxt;
    logic            phase_q;
    logic            start_req;
    logic            in_seq;
    logic            ovf_set;
    logic            ctr_direct;
    logic            pend_vld_q;
    logic [AW-1:0]   pend_base_q;
    logic [6:0]      pend_fill_q;
    logic [AW-1:0]   last_a_q, last_b_q;
    logic [PIPE-1:0] pipe_q;
    logic [AW-1:0]   two_k;
    logic [6:0]      age_a, age_b;

    // A strobe on the odd phase completes a sample pair and requests a new output.
    assign start_req = clk_vld_in & phase_q;
    assign in_seq    = (state_q != IDLE);

    // Fill seen by a sequence includes the sample being written in the start cycle.
    assign fill_nxt = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 7'd1;

    // Tap ages relative to x[n]: A walks forward from age 1, B walks back from age 75.
    assign two_k = AW'({k_q, 1'b0});
    assign age_a = {1'b0, k_q, 1'b0} + 7'd1;
    assign age_b = 7'd75 - {1'b0, k_q, 1'b0};

    // Ring write pointer, phase bit and saturating fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= '0;
            phase_q <= 1'b0;
            fill_q  <= '0;
        end else if (clk_vld_in) begin
            wr_addr <= wr_addr + AW'(1);
            phase_q <= ~phase_q;
            fill_q  <= fill_nxt;
        end
    end

`ifdef HB_MAC_SCHED_PEND_EN
    logic pend_take;

    // A request landing in CTR with an empty slot starts directly rather than
    // parking in the slot, otherwise it would be stranded once CTR goes IDLE.
    assign ctr_direct = (state_q == CTR) & start_req & ~pend_vld_q;
    assign pend_take  = start_req & in_seq & ~pend_vld_q & (state_q != CTR);
    assign ovf_set    = start_req & in_seq & pend_vld_q;

    // One-deep pending slot: captures base and fill, emptied when CTR consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q  <= 1'b0;
            pend_base_q <= '0;
            pend_fill_q <= '0;
        end else if (pend_take) begin
            pend_vld_q  <= 1'b1;
            pend_base_q <= wr_addr;
            pend_fill_q <= fill_nxt;
        end else if (state_q == CTR) begin
            pend_vld_q  <= 1'b0;
        end
    end
`else
    assign ctr_direct  = 1'b0;
    assign ovf_set     = start_req & in_seq;
    assign pend_vld_q  = 1'b0;
    assign pend_base_q = '0;
    assign pend_fill_q = '0;
`endif

    // Next-state: IDLE -> MAC k=0..18 -> CTR -> (MAC again if work queued, else IDLE).
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        fcap_d  = fcap_q;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = MAC;
                    k_d     = '0;
                    base_d  = wr_addr;
                    fcap_d  = fill_nxt;
                end
            end
            MAC: begin
                if (k_q == K_LAST) begin
                    state_d = CTR;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            CTR: begin
                if (pend_vld_q) begin
                    state_d = MAC;
                    k_d     = '0;
                    base_d  = pend_base_q;
                    fcap_d  = pend_fill_q;
                end else if (ctr_direct) begin
                    state_d = MAC;
                    k_d     = '0;
                    base_d  = wr_addr;
                    fcap_d  = fill_nxt;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            base_q  <= '0;
            fcap_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            fcap_q  <= fcap_d;
        end
    end

    // Per-step outputs; read addresses hold their last value when no step is active.
    always_comb begin
        rd_addr_a = last_a_q;
        rd_addr_b = last_b_q;
        rd_a_vld  = 1'b0;
        rd_b_vld  = 1'b0;
        coef_idx  = '0;
        coef_neg  = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            MAC: begin
                rd_addr_a = base_q - AW'(1) - two_k;
                rd_addr_b = base_q - AW'(75) + two_k;
                rd_a_vld  = (age_a < fcap_q);
                rd_b_vld  = (age_b < fcap_q);
                coef_idx  = k_q;
                coef_neg  = k_q[0];
                acc_clr   = (k_q == 5'd0);
                acc_en    = 1'b1;
                busy      = 1'b1;
            end
            CTR: begin
                rd_addr_a = base_q - AW'(38);
                rd_a_vld  = (7'd38 < fcap_q);
                coef_idx  = 5'd19;
                acc_en    = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Remember the last driven read addresses so they stay stable between sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_a_q <= '0;
            last_b_q <= '0;
        end else begin
            last_a_q <= rd_addr_a;
            last_b_q <= rd_addr_b;
        end
    end

    // Delay the CTR step by the datapath depth to flag the finished accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= (state_q == CTR);
            for (int i = 1; i < PIPE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign clk_vld_out = pipe_q[PIPE-1];

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hb_mac_sched.sv
// Directed bench for hb_mac_sched: fill-dependent taps, wrap, overrun/pending, reset mid-sequence.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: none; stimulus is a fixed schedule.
module tb_hb_mac_sched;

    localparam int AW   = 7;
    localparam int PIPE = 2;
`ifdef HB_MAC_SCHED_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_vld_in;
    logic          ovf_clr;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic          rd_a_vld, rd_b_vld;
    logic [4:0]    coef_idx;
    logic          coef_neg, acc_clr, acc_en, busy, clk_vld_out, ovf;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int n_str    = 0;
    int out_cnt  = 0;

    hb_mac_sched #(.AW(AW), .PIPE(PIPE)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_vld_in  (clk_vld_in),
        .ovf_clr     (ovf_clr),
        .wr_addr     (wr_addr),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_a_vld    (rd_a_vld),
        .rd_b_vld    (rd_b_vld),
        .coef_idx    (coef_idx),
        .coef_neg    (coef_neg),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .busy        (busy),
        .clk_vld_out (clk_vld_out),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Count decimated-output pulses away from the active edge.
    always @(negedge clk) begin
        if (clk_vld_out === 1'b1) out_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        clk_vld_in = 1'b1;
        tick();
        clk_vld_in = 1'b0;
        n_str++;
    endtask

    // Issue a start strobe and walk the whole sequence against the tap model.
    task automatic run_seq();
        int            base, f;
        logic [AW-1:0] ea, eb;
        base = n_str % 128;
        f    = (n_str + 1 > 76) ? 76 : n_str + 1;
        strobe();
        check("wr_addr_adv", 32'(wr_addr), 32'((base + 1) % 128));
        for (int k = 0; k < 19; k++) begin
            if (k > 0) tick();
            ea = AW'(base - 1 - 2 * k);
            eb = AW'(base - 75 + 2 * k);
            check("mac_addr_a", 32'(rd_addr_a), 32'(ea));
            check("mac_addr_b", 32'(rd_addr_b), 32'(eb));
            check("mac_a_vld", 32'(rd_a_vld), 32'(1 + 2 * k < f));
            check("mac_b_vld", 32'(rd_b_vld), 32'(75 - 2 * k < f));
            check("mac_coef_idx", 32'(coef_idx), 32'(k));
            check("mac_coef_neg", 32'(coef_neg), 32'(k % 2));
            check("mac_acc_clr", 32'(acc_clr), 32'(k == 0));
            check("mac_acc_en", 32'(acc_en), 32'd1);
        end
        tick();
        ea = AW'(base - 38);
        check("ctr_addr_a", 32'(rd_addr_a), 32'(ea));
        check("ctr_a_vld", 32'(rd_a_vld), 32'(38 < f));
        check("ctr_b_vld", 32'(rd_b_vld), 32'd0);
        check("ctr_coef_idx", 32'(coef_idx), 32'd19);
        check("ctr_coef_neg", 32'(coef_neg), 32'd0);
        check("ctr_acc_en", 32'(acc_en), 32'd1);
        tick();
        check("out_early", 32'(clk_vld_out), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        tick();
        check("out_pulse", 32'(clk_vld_out), 32'd1);
    endtask

    initial begin
        int            n0, cnt0;
        logic [AW-1:0] ea;

        rst        = 1'b1;
        clk_vld_in = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acc_en", 32'(acc_en), 32'd0);
        check("rst_addr_a", 32'(rd_addr_a), 32'd0);
        check("rst_addr_b", 32'(rd_addr_b), 32'd0);
        check("rst_out", 32'(clk_vld_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // First pair: second strobe starts with base 1, fill 2.
        strobe();
        check("first_no_start", 32'(busy), 32'd0);
        repeat (29) tick();
        run_seq();

        // Warm-up to full fill, then a fully valid sequence.
        while (n_str < 79) begin
            strobe();
            repeat (11) tick();
        end
        repeat (20) tick();
        check("warm_ovf", 32'(ovf), 32'd0);
        run_seq();

        // Past the 128-entry wrap: base 11 gives tap B at 64 for k=0.
        while (n_str < 139) begin
            strobe();
            repeat (11) tick();
        end
        repeat (20) tick();
        run_seq();

        // Overrun / pending schedule: a strobe every 4 cycles, starts every 8.
        strobe();
        repeat (25) tick();
        n0   = n_str;
        cnt0 = out_cnt;
        for (int c = 0; c < 70; c++) begin
            int cy;
            clk_vld_in = (c % 4 == 0) && (c <= 32);
            ovf_clr    = (c == 18) || (c == 32) || (c == 34);
            tick();
            if (clk_vld_in) n_str++;
            clk_vld_in = 1'b0;
            ovf_clr    = 1'b0;
            cy = c + 1;
            if (cy == 1)  check("sch_first_clr", 32'(acc_clr), 32'd1);
            if (cy == 9)  check("sch_ovf9", 32'(ovf), 32'(!PEND));
            if (cy == 17) check("sch_ovf17", 32'(ovf), 32'd1);
            if (cy == 19) check("sch_ovf_clr", 32'(ovf), 32'd0);
            if (cy == 20) check("sch_ctr", 32'(coef_idx), 32'd19);
            if (cy == 21) begin
                ea = PEND ? AW'(n0 + 2 - 1) : AW'(n0 - 38);
                check("sch_busy21", 32'(busy), 32'(PEND));
                check("sch_clr21", 32'(acc_clr), 32'(PEND));
                check("sch_addr21", 32'(rd_addr_a), 32'(ea));
            end
            if (cy == 22) check("sch_out22", 32'(clk_vld_out), 32'd1);
            if (cy == 25) check("sch_clr25", 32'(acc_clr), 32'(!PEND));
            if (cy == 33) check("sch_ovf_setwins", 32'(ovf), 32'd1);
            if (cy == 35) check("sch_ovf_clr2", 32'(ovf), 32'd0);
        end
        check("sch_pulses", 32'(out_cnt - cnt0), PEND ? 32'd3 : 32'd2);

        // Reset at MAC k=9.
        strobe();
        repeat (5) tick();
        strobe();
        repeat (9) tick();
        check("k9_coef", 32'(coef_idx), 32'd9);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        n_str = 0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_acc_en", 32'(acc_en), 32'd0);
        check("mid_rst_coef", 32'(coef_idx), 32'd0);
        check("mid_rst_addr_a", 32'(rd_addr_a), 32'd0);
        check("mid_rst_addr_b", 32'(rd_addr_b), 32'd0);
        check("mid_rst_a_vld", 32'(rd_a_vld), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        cnt0 = out_cnt;
        repeat (30) tick();
        check("mid_rst_no_out", 32'(out_cnt - cnt0), 32'd0);

        // Reset while the completion pulse is in flight.
        strobe();
        repeat (3) tick();
        strobe();
        repeat (20) tick();
        cnt0 = out_cnt;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        check("flight_out", 32'(clk_vld_out), 32'd0);
        repeat (5) tick();
        check("flight_cancel", 32'(out_cnt - cnt0), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
